// File: rtl/neg_pkg.sv
// Shared constants and state encoding for the chunked negation engine.
package neg_pkg;

  localparam int SIZE_DEF  = 64;
  localparam int CHUNK_DEF = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Most-negative operand; its negation is not representable.
  localparam logic [SIZE_DEF-1:0] MIN_VAL = {1'b1, {(SIZE_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_BUSY = S_BUSY,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/neg_chunk.sv
// One CHUNK-wide slice of a two's-complement negator: {cout, s} = ~a + cin,
// built as an inverter stage feeding a ripple chain of full-adder cells.
module neg_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK-1:0] w_na;
  logic [CHUNK-1:0] w_b;
  logic [CHUNK:0]   w_c;

  assign w_na   = ~a;
  assign w_b    = '0;
  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic w_p;
    assign w_p      = w_na[i] ^ w_b[i];
    assign s[i]     = w_p ^ w_c[i];
    assign w_c[i+1] = (w_na[i] & w_b[i]) | (w_p & w_c[i]);
  end

  assign cout = w_c[CHUNK];

endmodule

// File: rtl/neg_sched.sv
// Shared multi-cycle negation engine: round-robin arbitration between two
// requesters, CHUNK bits negated per BUSY cycle with the carry held between
// cycles, result returned over a valid/ready handshake.
module neg_sched
  import neg_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [SIZE-1:0] req0_a,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SIZE-1:0] req1_a,
  output logic            req1_ready,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [SIZE-1:0] res_data,
  output logic            res_id,
  output logic            res_ovf,
  output logic            busy
);

  localparam int K     = SIZE / CHUNK;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
  localparam logic [SIZE-1:0]  L_MIN    = {1'b1, {(SIZE-1){1'b0}}};

  state_e           r_state;
  state_e           w_next;
  logic             r_last;
  logic [SIZE-1:0]  r_op;
  logic [SIZE-1:0]  r_res;
  logic             r_id;
  logic             r_ovf;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_accept;
  logic [SIZE-1:0]  w_a;
  logic [CHUNK-1:0] w_slice;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;

  // Arbitration and next-state: grants only in IDLE, never both at once.
  always_comb begin
    w_next = r_state;
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rdy0 = req0_valid & (~req1_valid | r_last);
        w_rdy1 = req1_valid & (~req0_valid | ~r_last);
        if (w_rdy0 | w_rdy1) w_next = ST_BUSY;
      end
      ST_BUSY: if (r_idx == LAST_IDX) w_next = ST_DONE;
      ST_DONE: if (res_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = w_rdy0 | w_rdy1;
  assign w_a      = w_rdy1 ? req1_a : req0_a;

  // Select the operand chunk addressed by the current index.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < K; k++) begin
      if (r_idx == IDX_W'(k)) w_slice = r_op[k*CHUNK +: CHUNK];
    end
  end

  neg_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (w_slice),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Operand capture on accept, chunk-by-chunk result build while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_op    <= '0;
      r_res   <= '0;
      r_id    <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_op    <= w_a;
        r_id    <= w_rdy1;
        r_last  <= w_rdy1;
        r_ovf   <= (w_a == L_MIN);
        r_res   <= '0;
        r_carry <= 1'b1;
        r_idx   <= '0;
      end
    end else if (r_state == ST_BUSY) begin
      for (int k = 0; k < K; k++) begin
        if (r_idx == IDX_W'(k)) r_res[k*CHUNK +: CHUNK] <= w_s;
      end
      r_carry <= w_cout;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign res_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign res_data   = r_res;
  assign res_id     = r_id;
  assign res_ovf    = r_ovf;

endmodule
